// File: rtl/spi_master_cfg_pkg.sv
// Shared constants for the configurable SPI master: FSM encoding and SPI mode codes.
package spi_master_cfg_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LEAD  = 3'd1;
  localparam logic [2:0] ST_XFER  = 3'd2;
  localparam logic [2:0] ST_TRAIL = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Mode codes are {cpol, cpha}.
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_master_cfg_clk_tick.sv
// Loadable down-counter: holds div while disabled, then pulses tick every div+1 enabled cycles.
module spi_clk_tick #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 CLK50MHZ,
  input  logic                 RST,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt;

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      cnt <= '0;
    end else if (!enable || (cnt == '0)) begin
      cnt <= div;
    end else begin
      cnt <= cnt - DIV_WIDTH'(1);
    end
  end

  assign tick = enable && (cnt == '0);

endmodule

// File: rtl/spi_master_cfg.sv
// SPI master with per-transfer mode, length, bit order, SCK divider and chip-select selection.
// Handshake: spi_trig is a request sampled only in IDLE; spi_busy covers LEAD..DONE, spi_done pulses once.
module spi_master_cfg
  import spi_master_cfg_pkg::*;
#(
  parameter  int MAX_WIDTH = 32,
  parameter  int NCS       = 4,
  parameter  int DIV_WIDTH = 8,
  localparam int LEN_W     = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1,
  localparam int CS_W      = (NCS > 1) ? $clog2(NCS) : 1
) (
  input  logic                 CLK50MHZ,
  input  logic                 RST,
  input  logic                 spi_trig,
  input  logic [MAX_WIDTH-1:0] data_in,
  input  logic [LEN_W-1:0]     len,
  input  logic [CS_W-1:0]      cs_sel,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic                 lsb_first,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 spi_sck,
  output logic [NCS-1:0]       spi_cs,
  output logic                 spi_mosi,
  input  logic                 spi_miso,
  output logic [MAX_WIDTH-1:0] data_out,
  output logic                 spi_busy,
  output logic                 spi_done,
  output logic [2:0]           dbg_state
);

  logic [2:0]           state;
  logic [LEN_W-1:0]     len_r;
  logic [CS_W-1:0]      cs_r;
  logic                 cpol_r, cpha_r, lsb_r, sck_r;
  logic [DIV_WIDTH-1:0] div_r;
  logic [MAX_WIDTH-1:0] tx_sr, rx_sr;
  logic [LEN_W:0]       edge_cnt;

  logic                 active, tick, last_edge, sample_edge, tx_head, first_bit;
  logic [MAX_WIDTH-1:0] tx_load, tx_next, rx_next;
  logic [LEN_W-1:0]     top_sh, rx_sh;

  assign active = (state == ST_LEAD) || (state == ST_XFER) || (state == ST_TRAIL);

  // In IDLE the counter preloads the live div so LEAD starts with the value being latched.
  spi_clk_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
    .CLK50MHZ (CLK50MHZ),
    .RST      (RST),
    .enable   (active),
    .div      ((state == ST_IDLE) ? div : div_r),
    .tick     (tick)
  );

  // MSB-first words are left-aligned so the shift register always emits from its top bit.
  assign top_sh      = LEN_W'(MAX_WIDTH - 1) - len;
  assign rx_sh       = LEN_W'(MAX_WIDTH - 1) - len_r;
  assign tx_load     = lsb_first ? data_in : (data_in << top_sh);
  assign first_bit   = lsb_first ? tx_load[0] : tx_load[MAX_WIDTH-1];
  assign tx_head     = lsb_r ? tx_sr[0] : tx_sr[MAX_WIDTH-1];
  assign tx_next     = lsb_r ? (tx_sr >> 1) : (tx_sr << 1);
  assign rx_next     = lsb_r ? {spi_miso, rx_sr[MAX_WIDTH-1:1]} : {rx_sr[MAX_WIDTH-2:0], spi_miso};
  assign last_edge   = (edge_cnt == {len_r, 1'b1});
  assign sample_edge = (edge_cnt[0] == cpha_r);

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      state    <= ST_IDLE;
      len_r    <= '0;
      cs_r     <= '0;
      cpol_r   <= 1'b0;
      cpha_r   <= 1'b0;
      lsb_r    <= 1'b0;
      div_r    <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      sck_r    <= 1'b0;
      edge_cnt <= '0;
      spi_mosi <= 1'b0;
      data_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (spi_trig) begin
            len_r    <= len;
            cs_r     <= cs_sel;
            cpol_r   <= cpol;
            cpha_r   <= cpha;
            lsb_r    <= lsb_first;
            div_r    <= div;
            sck_r    <= cpol;
            edge_cnt <= '0;
            rx_sr    <= '0;
            if (!cpha) begin
              spi_mosi <= first_bit;
              tx_sr    <= lsb_first ? (tx_load >> 1) : (tx_load << 1);
            end else begin
              spi_mosi <= 1'b0;
              tx_sr    <= tx_load;
            end
            state <= ST_LEAD;
          end
        end
        ST_LEAD: if (tick) state <= ST_XFER;
        ST_XFER: begin
          if (tick) begin
            sck_r    <= ~sck_r;
            edge_cnt <= edge_cnt + (LEN_W + 1)'(1);
            if (sample_edge) begin
              rx_sr <= rx_next;
            end else if (!last_edge) begin
              spi_mosi <= tx_head;
              tx_sr    <= tx_next;
            end
            if (last_edge) state <= ST_TRAIL;
          end
        end
        ST_TRAIL: begin
          if (tick) begin
            spi_mosi <= 1'b0;
            data_out <= lsb_r ? (rx_sr >> rx_sh) : rx_sr;
            state    <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    spi_cs = '1;
    if (active && (int'(cs_r) < NCS)) spi_cs[cs_r] = 1'b0;
  end

  assign spi_sck   = (state == ST_IDLE) ? cpol : sck_r;
  assign spi_busy  = (state != ST_IDLE);
  assign spi_done  = (state == ST_DONE);
  assign dbg_state = state;

endmodule
